// File: rtl/reg_writeback_ctrl_if.sv
// Bus bundle for the register-file writeback controller: request queue input,
// data-memory read port, register-file write port and hazard lookup.
interface reg_writeback_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    localparam int NREG = 2 ** ADDR_W;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_dest;
    logic              in_is_load;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] in_addr;

    logic              mem_req;
    logic [DATA_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              RegWrite;
    logic [ADDR_W-1:0] RegDst;
    logic [DATA_W-1:0] Mem_to_Reg;

    logic [NREG-1:0]   busy;
    logic [ADDR_W-1:0] chk_ra;
    logic [ADDR_W-1:0] chk_rb;
    logic              hazard;

    modport master (
        output in_valid, in_dest, in_is_load, in_data, in_addr,
        output mem_ack, mem_rdata, chk_ra, chk_rb,
        input  in_ready, mem_req, mem_addr, RegWrite, RegDst, Mem_to_Reg, busy, hazard
    );

    modport slave (
        input  in_valid, in_dest, in_is_load, in_data, in_addr,
        input  mem_ack, mem_rdata, chk_ra, chk_rb,
        output in_ready, mem_req, mem_addr, RegWrite, RegDst, Mem_to_Reg, busy, hazard
    );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// In-order writeback controller: queues ALU/load results, fetches load data over
// req/ack, issues one register-file write per request and tracks pending writes.
module reg_writeback_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input logic clk,
    input logic rst,
    reg_writeback_ctrl_if.slave bus
);
    localparam int NREG  = 2 ** ADDR_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_WRITE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] q_dest_q [DEPTH], q_dest_d [DEPTH];
    logic              q_load_q [DEPTH], q_load_d [DEPTH];
    logic [DATA_W-1:0] q_val_q  [DEPTH], q_val_d  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  cnt_q [NREG], cnt_d [NREG];
    logic              mem_req_q, mem_req_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] reg_dst_q, reg_dst_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] cur_dest_q, cur_dest_d;

    logic              in_ready;
    logic              push, pop, retire;
    logic [NREG-1:0]   busy;

    assign in_ready = (count_q != CNT_W'(DEPTH));
    assign push     = bus.in_valid && in_ready;
    assign pop      = (state_q == S_IDLE) && (count_q != '0);
    assign retire   = (state_q == S_WRITE) && reg_write_q;

    always_comb begin
        q_dest_d = q_dest_q;
        q_load_d = q_load_q;
        q_val_d  = q_val_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            q_dest_d[wr_ptr_q] = bus.in_dest;
            q_load_d[wr_ptr_q] = bus.in_is_load;
            q_val_d[wr_ptr_q]  = bus.in_is_load ? bus.in_addr : bus.in_data;
            wr_ptr_d           = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    // Register 0 is never written, so its counter is pinned at zero.
    always_comb begin
        cnt_d[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            logic inc, dec;
            inc = push && (bus.in_dest == ADDR_W'(r));
            dec = retire && (reg_dst_q == ADDR_W'(r));
            cnt_d[r] = cnt_q[r];
            if (inc && !dec)      cnt_d[r] = cnt_q[r] + CNT_W'(1);
            else if (dec && !inc) cnt_d[r] = cnt_q[r] - CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        reg_write_d = reg_write_q;
        reg_dst_d   = reg_dst_q;
        wdata_d     = wdata_q;
        cur_dest_d  = cur_dest_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    if (q_load_q[rd_ptr_q]) begin
                        state_d    = S_MEM;
                        mem_req_d  = 1'b1;
                        mem_addr_d = q_val_q[rd_ptr_q];
                        cur_dest_d = q_dest_q[rd_ptr_q];
                    end else begin
                        state_d     = S_WRITE;
                        wdata_d     = q_val_q[rd_ptr_q];
                        reg_dst_d   = q_dest_q[rd_ptr_q];
                        reg_write_d = (q_dest_q[rd_ptr_q] != '0);
                    end
                end
            end
            S_MEM: begin
                if (bus.mem_ack) begin
                    state_d     = S_WRITE;
                    mem_req_d   = 1'b0;
                    wdata_d     = bus.mem_rdata;
                    reg_dst_d   = cur_dest_q;
                    reg_write_d = (cur_dest_q != '0);
                end
            end
            S_WRITE: begin
                state_d     = S_IDLE;
                reg_write_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            reg_write_q <= 1'b0;
            reg_dst_q   <= '0;
            wdata_q     <= '0;
            cur_dest_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_dest_q[i] <= '0;
                q_load_q[i] <= 1'b0;
                q_val_q[i]  <= '0;
            end
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            reg_write_q <= reg_write_d;
            reg_dst_q   <= reg_dst_d;
            wdata_q     <= wdata_d;
            cur_dest_q  <= cur_dest_d;
            q_dest_q    <= q_dest_d;
            q_load_q    <= q_load_d;
            q_val_q     <= q_val_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) busy[r] = (cnt_q[r] != '0);
    end

    assign bus.in_ready   = in_ready;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.RegWrite   = reg_write_q;
    assign bus.RegDst     = reg_dst_q;
    assign bus.Mem_to_Reg = wdata_q;
    assign bus.busy       = busy;
    assign bus.hazard     = busy[bus.chk_ra] | busy[bus.chk_rb];
endmodule
